// File: rtl/conv10_argmax.sv
// Streaming argmax over one frame of signed class scores. It reports the winning
// class, its score, the saturated top-2 margin and a confidence flag.
module conv10_argmax #(
   parameter int                NUM_CLASSES = 8,
   parameter int                DATA_W      = 16,
   parameter int                IDX_W       = 3,
   parameter logic [DATA_W-1:0] CONF_THRESH = 16'd256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              score_valid,
   input  logic [DATA_W-1:0] score_data,
   output logic              score_ready,
   output logic              busy,
   output logic              done,
   output logic              result_valid,
   output logic [IDX_W-1:0]  class_idx,
   output logic [DATA_W-1:0] class_score,
   output logic [DATA_W-1:0] margin,
   output logic              conf_flag
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]         LAST_BEAT = IDX_W'(NUM_CLASSES - 1);

   // best >= second always holds, so the widened difference is non-negative
   function automatic logic [DATA_W-1:0] sat_margin(input logic signed [DATA_W-1:0] hi,
                                                    input logic signed [DATA_W-1:0] lo);
      logic [DATA_W:0] diff;
      diff = {hi[DATA_W-1], hi} - {lo[DATA_W-1], lo};
      if (diff[DATA_W]) begin
         sat_margin = {DATA_W{1'b1}};
      end else begin
         sat_margin = diff[DATA_W-1:0];
      end
   endfunction

   state_t                    state_r, next_state_s;
   logic [IDX_W-1:0]          cnt_r;
   logic signed [DATA_W-1:0]  best_r, second_r;
   logic [IDX_W-1:0]          best_idx_r;
   logic                      score_ready_r, busy_r, done_r, result_valid_r, conf_flag_r;
   logic [IDX_W-1:0]          class_idx_r;
   logic [DATA_W-1:0]         class_score_r, margin_r;

   logic                      accept_s, last_beat_s, start_accept_s;
   logic signed [DATA_W-1:0]  beat_s, new_best_s, new_second_s;
   logic [IDX_W-1:0]          new_idx_s;
   logic [DATA_W-1:0]         margin_s;
   logic                      conf_s;

   assign accept_s       = score_valid & score_ready_r;
   assign last_beat_s    = (cnt_r == LAST_BEAT);
   assign start_accept_s = start & (state_r != ST_COLLECT);
   assign beat_s         = score_data;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; start is ignored while a frame is being collected
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_state_s = ST_COLLECT;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (accept_s && last_beat_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_COLLECT;
            end
         end
         ST_DONE: begin
            if (start) begin
               next_state_s = ST_COLLECT;
            end else begin
               next_state_s = ST_DONE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Top-2 update for the current beat; strict compares keep the lower index on ties
   always_comb begin
      new_best_s   = best_r;
      new_second_s = second_r;
      new_idx_s    = best_idx_r;
      if (beat_s > best_r) begin
         new_best_s   = beat_s;
         new_second_s = best_r;
         new_idx_s    = cnt_r;
      end else if (beat_s > second_r) begin
         new_second_s = beat_s;
      end else begin
         new_second_s = second_r;
      end
      margin_s = sat_margin(new_best_s, new_second_s);
      conf_s   = (margin_s >= CONF_THRESH);
   end

   // Frame datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r          <= {IDX_W{1'b0}};
         best_r         <= {DATA_W{1'b0}};
         second_r       <= {DATA_W{1'b0}};
         best_idx_r     <= {IDX_W{1'b0}};
         score_ready_r  <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         result_valid_r <= 1'b0;
         class_idx_r    <= {IDX_W{1'b0}};
         class_score_r  <= {DATA_W{1'b0}};
         margin_r       <= {DATA_W{1'b0}};
         conf_flag_r    <= 1'b0;
      end else begin
         score_ready_r <= (next_state_s == ST_COLLECT);
         busy_r        <= (next_state_s == ST_COLLECT);
         done_r        <= 1'b0;
         if (start_accept_s) begin
            cnt_r          <= {IDX_W{1'b0}};
            best_r         <= SCORE_MIN;
            second_r       <= SCORE_MIN;
            best_idx_r     <= {IDX_W{1'b0}};
            result_valid_r <= 1'b0;
         end else if (accept_s) begin
            cnt_r      <= cnt_r + IDX_W'(1);
            best_r     <= new_best_s;
            second_r   <= new_second_s;
            best_idx_r <= new_idx_s;
            if (last_beat_s) begin
               class_idx_r    <= new_idx_s;
               class_score_r  <= new_best_s;
               margin_r       <= margin_s;
               conf_flag_r    <= conf_s;
               done_r         <= 1'b1;
               result_valid_r <= 1'b1;
            end
         end
      end
   end

   assign score_ready  = score_ready_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign result_valid = result_valid_r;
   assign class_idx    = class_idx_r;
   assign class_score  = class_score_r;
   assign margin       = margin_r;
   assign conf_flag    = conf_flag_r;

endmodule
